uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- UART receive path: oversampled serial input to parallel word, with start-bit glitch rejection and framing/overrun detection.
- Sits between the rx pad (via internal synchroniser) and the host-side register interface.
- Completes the link opposite the transmitter.
- Received word is held in a holding register until the host acknowledges it.

Parameters:
numBit, 8, data bits per frame (5..16), LSB first
BAUD_DIV, 4, clk cycles per oversample tick (>=1)
OVS, 16, oversample ticks per bit period (even, >=4)

Ports:
clk  input  1  system clock, all logic on rising edge
RSTn  input  1  asynchronous active-low reset
rx  input  1  serial line, asynchronous, idle high
rd_en  input  1  host acknowledge; consumes held word
data_out  output  numBit  last accepted word
data_valid  output  1  data_out holds unread word
frame_err  output  1  one-cycle pulse, stop bit sampled low
overrun_err  output  1  sticky, frame completed while data_valid=1
parity_err  output  1  one-cycle pulse, parity mismatch (see Optional Feature)

Behaviour:
- Reset: async on RSTn low. Reset values:
  - Outputs: data_out=0, data_valid=0, frame_err=0, overrun_err=0, parity_err=0.
  - Internal: FSM=IDLE, all counters 0, synchroniser flops=1.
- Input conditioning: rx passes through a 2-flop synchroniser; rx_s is the 2nd flop.
- Falling-edge detect compares rx_s with a 3rd flop.
- Tick generator: counter runs 0..BAUD_DIV-1 in every state. tick=1 for one clk when count==BAUD_DIV-1, then wraps to 0.
- Counters: sample counter s_cnt counts ticks, 0..OVS-1. Bit counter b_cnt counts 0..numBit-1.
- FSM IDLE: on rx_s falling edge -> START, s_cnt=0.
- FSM START: on the tick where s_cnt==OVS/2-1 (mid start bit):
  - rx_s=0 -> DATA, s_cnt=0, b_cnt=0.
  - rx_s=1 -> IDLE (glitch rejected, no output activity).
- FSM DATA: on the tick where s_cnt==OVS-1, shift rx_s into bit b_cnt of the shift register (LSB first).
  - b_cnt<numBit-1: b_cnt++.
  - b_cnt==numBit-1: -> PARITY if the macro is defined, else -> STOP.
- FSM STOP: on the tick where s_cnt==OVS-1:
  - rx_s=1, valid frame: load data_out, data_valid=1 on the next clk edge.
  - rx_s=0: frame_err pulses 1 clk; data_out and data_valid unchanged.
  - Either case -> IDLE.
- Latency: data_valid rises 1 clk after the mid-stop-bit sample edge.
- Overrun (valid frame completes while data_valid=1 and rd_en=0 that cycle):
  - New word is dropped; data_out keeps the old word.
  - overrun_err=1 until the next rd_en.
- rd_en: clears data_valid and overrun_err on the next edge.
  - rd_en with data_valid=0 has no effect.
  - rd_en in the same cycle as a new load: the load wins. data_valid stays 1, data_out takes the new word, no overrun.
- Break (line held low): the frame ends in a framing error.
  - A new start requires a fresh falling edge, so IDLE waits until rx returns high.
- Reset mid-frame: frame discarded; FSM restarts from IDLE after RSTn deassertion.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - One even-parity bit follows the data bits, in state PARITY, sampled at s_cnt==OVS-1.
  - Mismatch vs XOR of the data bits: parity_err pulses 1 clk when the stop bit is sampled, and the word is not loaded.
  - Frame length is 1+numBit+1+1 bits.
- Not defined: no PARITY state; parity_err tied 0; frame length 1+numBit+1 bits.

Test Plan:
All scenarios use BAUD_DIV=4, OVS=16 (64 clk/bit), numBit=8, macro undefined unless noted.
- Basic receive: send 0xA5, stop=1 -> data_valid=1 and data_out=0xA5, exactly 1 clk after the mid-stop sample. Pulse rd_en -> data_valid=0 next clk.
- Glitch: drive rx low for 20 clk (<32) then high -> FSM back to IDLE; data_valid, frame_err, overrun_err all stay 0.
- Framing error: send 0x3C with stop=0 -> frame_err pulses exactly 1 clk; data_valid stays 0; data_out unchanged (0x00 after reset).
- Overrun: send 0x11 then 0x22 with no rd_en -> data_out=0x11, overrun_err=1. rd_en -> overrun_err=0, data_valid=0.
- Reset mid-frame: assert RSTn low during bit 3 of 0xFF -> all outputs 0 immediately. Then send 0x5A -> data_out=0x5A received correctly.
- Parity (macro defined): send 0x07 with parity bit 1 -> data_out=0x07, parity_err=0. Send 0x07 with parity bit 0 -> parity_err pulses 1 clk, data_valid stays 0.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: oversampled UART receiver, LSB-first, 1 start / numBit data /
// [1 even parity] / 1 stop.  Start-bit glitch rejection at mid start bit,
// framing error pulse, sticky overrun flag, host holding register.
//
// Optional feature macro: UART_RX_PARITY_EN (adds one even-parity bit after
// the data bits; a mismatch pulses parity_err and drops the word).
//
// Ports:
//   clk         system clock, rising edge
//   RSTn        asynchronous active-low reset
//   rx          serial line, asynchronous, idle high
//   rd_en       host acknowledge, consumes the held word
//   data_out    last accepted word
//   data_valid  data_out holds an unread word
//   frame_err   1-clk pulse, stop bit sampled low
//   overrun_err sticky until rd_en, frame completed while data_valid=1
//   parity_err  1-clk pulse, parity mismatch (0 without the macro)
module uart_rx #(
  parameter int numBit   = 8,
  parameter int BAUD_DIV = 4,
  parameter int OVS      = 16
) (
  input  logic              clk,
  input  logic              RSTn,
  input  logic              rx,
  input  logic              rd_en,
  output logic [numBit-1:0] data_out,
  output logic              data_valid,
  output logic              frame_err,
  output logic              overrun_err,
  output logic              parity_err
);
  localparam int BDW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int SW  = $clog2(OVS);
  localparam int BW  = $clog2(numBit);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t            r_state;
  logic [2:0]        r_sync;
  logic [BDW-1:0]    r_bdiv;
  logic [SW-1:0]     r_scnt;
  logic [BW-1:0]     r_bcnt;
  logic [numBit-1:0] r_shift;
  logic [numBit-1:0] r_data;
  logic              r_valid;
  logic              r_ferr;
  logic              r_oerr;
  logic              r_perr;
  logic              w_rx_s;
  logic              w_fall;
  logic              w_tick;
  logic              w_mid;
  logic              w_end;
  logic              w_par_bad;

  // r_sync[1] is the synchronised line; r_sync[2] is one clk older for edge detect
  assign w_rx_s = r_sync[1];
  assign w_fall = r_sync[2] & ~r_sync[1];
  assign w_tick = (r_bdiv == BDW'(BAUD_DIV - 1));
  assign w_mid  = (r_scnt == SW'(OVS / 2 - 1));
  assign w_end  = (r_scnt == SW'(OVS - 1));

`ifdef UART_RX_PARITY_EN
  logic r_par_bad;
  assign w_par_bad = r_par_bad;
`else
  assign w_par_bad = 1'b0;
`endif

  assign data_out    = r_data;
  assign data_valid  = r_valid;
  assign frame_err   = r_ferr;
  assign overrun_err = r_oerr;
  assign parity_err  = r_perr;

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      r_sync <= 3'b111;
      r_bdiv <= '0;
    end else begin
      r_sync <= {r_sync[1:0], rx};
      r_bdiv <= w_tick ? '0 : r_bdiv + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      r_state   <= IDLE;
      r_scnt    <= '0;
      r_bcnt    <= '0;
      r_shift   <= '0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_ferr    <= 1'b0;
      r_oerr    <= 1'b0;
      r_perr    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_bad <= 1'b0;
`endif
    end else begin
      r_ferr <= 1'b0;
      r_perr <= 1'b0;
      // host ack; a load later in this block overrides the data_valid clear
      if (rd_en) begin
        r_valid <= 1'b0;
        r_oerr  <= 1'b0;
      end
      case (r_state)
        IDLE: begin
          r_scnt <= '0;
          if (w_fall) r_state <= START;
        end
        START: if (w_tick) begin
          if (w_mid) begin
            r_scnt <= '0;
            r_bcnt <= '0;
            // still low at mid start bit: real start, otherwise a glitch
            r_state <= w_rx_s ? IDLE : DATA;
          end else r_scnt <= r_scnt + 1'b1;
        end
        DATA: if (w_tick) begin
          if (w_end) begin
            r_scnt          <= '0;
            r_shift[r_bcnt] <= w_rx_s;
            if (r_bcnt == BW'(numBit - 1)) begin
`ifdef UART_RX_PARITY_EN
              r_state <= PARITY;
`else
              r_state <= STOP;
`endif
            end else r_bcnt <= r_bcnt + 1'b1;
          end else r_scnt <= r_scnt + 1'b1;
        end
`ifdef UART_RX_PARITY_EN
        PARITY: if (w_tick) begin
          if (w_end) begin
            r_scnt    <= '0;
            r_par_bad <= w_rx_s ^ (^r_shift);
            r_state   <= STOP;
          end else r_scnt <= r_scnt + 1'b1;
        end
`endif
        STOP: if (w_tick) begin
          if (w_end) begin
            r_scnt  <= '0;
            r_state <= IDLE;
            r_perr  <= w_par_bad;
            if (!w_rx_s) r_ferr <= 1'b1;
            else if (!w_par_bad) begin
              if (r_valid && !rd_en) r_oerr <= 1'b1;
              else begin
                r_data  <= r_shift;
                r_valid <= 1'b1;
              end
            end
          end else r_scnt <= r_scnt + 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx (numBit=8, BAUD_DIV=4, OVS=16).
// Frames are driven bit-serially; a frame-level model predicts the held word,
// flags and the exact clk edge at which the stop bit is sampled.
module tb_uart_rx;
  localparam int NBIT = 8;
  localparam int BDIV = 4;
  localparam int OVS  = 16;
  localparam int BP   = BDIV * OVS;
`ifdef UART_RX_PARITY_EN
  localparam int NB = NBIT + 3;
`else
  localparam int NB = NBIT + 2;
`endif
  // ticks from entering START to the stop-bit sample
  localparam int NTICK = OVS / 2 + OVS * (NB - 1);

  logic            clk = 1'b0;
  logic            RSTn = 1'b0;
  logic            rx = 1'b1;
  logic            rd_en = 1'b0;
  logic [NBIT-1:0] data_out;
  logic            data_valid, frame_err, overrun_err, parity_err;

  int errs = 0;
  int checks = 0;
  int ecnt;  // rising edges since reset release; equals index of the next edge

  logic [7:0] m_do;
  logic       m_dv, m_ov;

  uart_rx #(.numBit(NBIT), .BAUD_DIV(BDIV), .OVS(OVS)) dut (
    .clk(clk), .RSTn(RSTn), .rx(rx), .rd_en(rd_en),
    .data_out(data_out), .data_valid(data_valid), .frame_err(frame_err),
    .overrun_err(overrun_err), .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk or negedge RSTn)
    if (!RSTn) ecnt <= 0;
    else       ecnt <= ecnt + 1;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic read_word();
    @(negedge clk); rd_en = 1'b1;
    @(negedge clk); rd_en = 1'b0;
    m_dv = 1'b0; m_ov = 1'b0;
    chk("rd_dv", data_valid, m_dv);
    chk("rd_ov", overrun_err, m_ov);
    chk("rd_do", data_out, m_do);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive one frame; rd_at_load asserts rd_en in the stop-sample cycle.
  task automatic send(input string tag, input logic [7:0] d, input logic stopb,
                      input logic parb, input logic rd_at_load, input logic keep_low);
    int E, f, S;
    logic [NB-1:0] bits;
    logic pre_dv, pre_fe, p_dv, p_ov, p_fe, p_pe, q_fe, q_pe;
    logic [7:0] p_do;
    logic good, exp_pe;
    bits = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < NBIT; i++) bits[1+i] = d[i];
`ifdef UART_RX_PARITY_EN
    bits[NBIT+1] = parb;
    exp_pe = (parb != ^d);
`else
    exp_pe = 1'b0;
`endif
    bits[NB-1] = stopb;
    @(negedge clk);
    E = ecnt;
    // START is entered at edge E+2; count ticks on edges E+3 onward
    f = E + 3;
    while (f % BDIV != BDIV - 1) f++;
    S = f + (NTICK - 1) * BDIV;
    {pre_dv, pre_fe, p_dv, p_ov, p_fe, p_pe, q_fe, q_pe, p_do} = '0;
    for (int st = 0; st < BP * NB; st++) begin
      rx = bits[st / BP];
      rd_en = rd_at_load && (ecnt == S);
      if (ecnt == S)     begin pre_dv = data_valid; pre_fe = frame_err; end
      if (ecnt == S + 1) begin
        p_dv = data_valid; p_ov = overrun_err; p_fe = frame_err;
        p_pe = parity_err; p_do = data_out;
      end
      if (ecnt == S + 2) begin q_fe = frame_err; q_pe = parity_err; end
      @(negedge clk);
    end
    rd_en = 1'b0;
    rx = !keep_low;
    chk({tag, "_pre_dv"}, pre_dv, m_dv);
    chk({tag, "_pre_fe"}, pre_fe, 1'b0);
    good = stopb && !exp_pe;
    if (rd_at_load) begin m_dv = 1'b0; m_ov = 1'b0; end
    if (good) begin
      if (m_dv) m_ov = 1'b1;
      else begin m_do = d; m_dv = 1'b1; end
    end
    chk({tag, "_dv"}, p_dv, m_dv);
    chk({tag, "_do"}, p_do, m_do);
    chk({tag, "_ov"}, p_ov, m_ov);
    chk({tag, "_fe"}, p_fe, !stopb);
    chk({tag, "_pe"}, p_pe, exp_pe);
    chk({tag, "_fe_end"}, q_fe, 1'b0);
    chk({tag, "_pe_end"}, q_pe, 1'b0);
  endtask

  initial begin
    logic seen;
    logic [7:0] rd;
    m_do = '0; m_dv = 1'b0; m_ov = 1'b0;
    // reset state
    #1;
    chk("rst_do", data_out, 8'h00);
    chk("rst_dv", data_valid, 1'b0);
    chk("rst_fe", frame_err, 1'b0);
    chk("rst_ov", overrun_err, 1'b0);
    chk("rst_pe", parity_err, 1'b0);
    idle(3);
    RSTn = 1'b1;
    idle(10);

    // basic receive and acknowledge
    send("basic", 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(5);
    read_word();

    // start-bit glitch shorter than half a bit
    @(negedge clk); rx = 1'b0;
    idle(20);
    rx = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      seen |= frame_err | data_valid | overrun_err;
    end
    chk("glitch_quiet", seen, 1'b0);

    // framing error
    send("frame", 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(20);

    // overrun: second word dropped
    send("ovr1", 8'h11, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(20);
    send("ovr2", 8'h22, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(5);
    chk("ovr_sticky", overrun_err, 1'b1);
    read_word();
    // ack with nothing held changes nothing
    read_word();

    // ack in the same cycle as a new load
    send("hold", 8'h33, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(20);
    send("ackload", 8'h44, 1'b1, 1'b0, 1'b1, 1'b0);
    idle(5);
    read_word();

    // break: line held low well past the frame, then released
    send("break", 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      seen |= frame_err | data_valid;
    end
    chk("break_no_refire", seen, 1'b0);
    rx = 1'b1;
    idle(100);

`ifdef UART_RX_PARITY_EN
    send("par_ok", 8'h07, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(5);
    read_word();
    send("par_bad", 8'h07, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(5);
`endif

    // randomised frames
    for (int k = 0; k < 8; k++) begin
      rd = 8'($urandom);
      if ($urandom_range(0, 2) == 0) read_word();
      send("rand", rd, ($urandom_range(0, 3) != 0), (^rd) ^ ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 4) == 0), 1'b0);
      idle($urandom_range(1, 40));
    end

    // reset in the middle of a frame (0xFF, during bit 3)
    send("prerst", 8'h66, 1'b1, 1'b1 ^ (^8'h66) ^ 1'b1, 1'b0, 1'b0);
    idle(5);
    @(negedge clk); rx = 1'b0;
    idle(BP);
    rx = 1'b1;
    idle(BP * 3 + BP / 2);
    RSTn = 1'b0;
    #1;
    m_do = '0; m_dv = 1'b0; m_ov = 1'b0;
    chk("mrst_do", data_out, 8'h00);
    chk("mrst_dv", data_valid, 1'b0);
    chk("mrst_fe", frame_err, 1'b0);
    chk("mrst_ov", overrun_err, 1'b0);
    chk("mrst_pe", parity_err, 1'b0);
    idle(3);
    RSTn = 1'b1;
    idle(20);
    send("after_rst", 8'h5A, 1'b1, ^8'h5A, 1'b0, 1'b0);
    idle(10);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
